// File: rtl/flag_branch_unit.sv
// flag_branch_unit: condition-code stage behind the saturating add/sub ALU.
// Holds the Z/N/V flag register, resolves 3-bit branch conditions and returns
// a registered taken/resolved pair to fetch, honouring pipeline stall/flush.
// Build option: define FLAG_BYPASS_EN to forward same-cycle ALU flags into
// branch evaluation (no hazard FSM, hazard_stall tied low). When undefined, a
// two-state IDLE/WAIT FSM raises a one-cycle hazard_stall whenever a branch
// arrives together with a flag write.
module flag_branch_unit #(
  parameter int COND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              alu_zr,
  input  logic              alu_neg,
  input  logic              alu_ov,
  input  logic              wr_z,
  input  logic              wr_n,
  input  logic              wr_v,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              br_taken,
  output logic              br_resolved,
  output logic              hazard_stall
);

  typedef enum logic [COND_W-1:0] {
    C_NEQ    = 3'b000,
    C_EQ     = 3'b001,
    C_GT     = 3'b010,
    C_LT     = 3'b011,
    C_GTE    = 3'b100,
    C_LTE    = 3'b101,
    C_OVF    = 3'b110,
    C_UNCOND = 3'b111
  } cond_t;

  logic  eff_z;
  logic  eff_n;
  logic  eff_v;
  logic  hazard;
  logic  cond_true;
  logic  advance;
  cond_t cond;

  // Flags may only change, and branches only resolve, when the pipe moves.
  assign advance = ~stall & ~flush;
  assign cond    = cond_t'(br_cond);

`ifdef FLAG_BYPASS_EN
  // Same-cycle forward of the ALU flags removes the read-after-write hazard.
  assign eff_z  = wr_z ? alu_zr  : flag_z;
  assign eff_n  = wr_n ? alu_neg : flag_n;
  assign eff_v  = wr_v ? alu_ov  : flag_v;
  assign hazard = 1'b0;
`else
  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state;

  assign eff_z = flag_z;
  assign eff_n = flag_n;
  assign eff_v = flag_v;

  // Branch colliding with a flag write in IDLE must wait one cycle for the flags.
  always_comb begin
    hazard = 1'b0;
    if (!rst && state == IDLE && br_valid && (wr_z || wr_n || wr_v) && advance)
      hazard = 1'b1;
  end

  // Hazard FSM: flush dominates stall; WAIT always falls back to IDLE when the pipe moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else if (!stall) begin
      unique case (state)
        IDLE:    state <= hazard ? WAIT : IDLE;
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign hazard_stall = hazard;

  // Condition decode against the effective flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      C_NEQ:    cond_true = ~eff_z;
      C_EQ:     cond_true = eff_z;
      C_GT:     cond_true = ~eff_z & ~eff_n;
      C_LT:     cond_true = eff_n;
      C_GTE:    cond_true = ~eff_n;
      C_LTE:    cond_true = eff_z | eff_n;
      C_OVF:    cond_true = eff_v;
      C_UNCOND: cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
  end

  // Architectural flag register, each flag under its own write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (advance) begin
      if (wr_z) flag_z <= alu_zr;
      if (wr_n) flag_n <= alu_neg;
      if (wr_v) flag_v <= alu_ov;
    end
  end

  // Registered branch outcome; a hazard cycle defers evaluation to the re-presented branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_resolved <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      br_resolved <= br_valid & advance & ~hazard;
      br_taken    <= br_valid & advance & ~hazard & cond_true;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Testbench for flag_branch_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the flag/branch rules.
module tb_flag_branch_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stall, flush;
  logic       alu_zr, alu_neg, alu_ov;
  logic       wr_z, wr_n, wr_v;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       flag_z, flag_n, flag_v;
  logic       br_taken, br_resolved, hazard_stall;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state
  bit m_z, m_n, m_v, m_wait, m_res, m_taken, m_haz;

  flag_branch_unit #(.COND_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .alu_zr(alu_zr), .alu_neg(alu_neg), .alu_ov(alu_ov),
    .wr_z(wr_z), .wr_n(wr_n), .wr_v(wr_v),
    .br_valid(br_valid), .br_cond(br_cond),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .br_taken(br_taken), .br_resolved(br_resolved), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic bit cond_of(input bit [2:0] c, input bit z, input bit n, input bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_hazard();
    if (BYPASS) return 1'b0;
    return !rst && !m_wait && br_valid && (wr_z || wr_n || wr_v) && !stall && !flush;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit ez, en, ev, go;
    if (rst) begin
      {m_z, m_n, m_v, m_wait, m_res, m_taken} = '0;
      return;
    end
    ez = (BYPASS && wr_z) ? alu_zr  : m_z;
    en = (BYPASS && wr_n) ? alu_neg : m_n;
    ev = (BYPASS && wr_v) ? alu_ov  : m_v;
    go = br_valid && !stall && !flush && !m_haz;
    m_res   = go;
    m_taken = go && cond_of(br_cond, ez, en, ev);
    if (!stall && !flush) begin
      if (wr_z) m_z = alu_zr;
      if (wr_n) m_n = alu_neg;
      if (wr_v) m_v = alu_ov;
    end
    if (flush)            m_wait = 1'b0;
    else if (stall)       m_wait = m_wait;
    else if (m_wait)      m_wait = 1'b0;
    else if (m_haz)       m_wait = 1'b1;
  endtask

  // Drive a full input vector just after the falling edge.
  task automatic drive(input bit r, input bit s, input bit f,
                       input bit zr, input bit ng, input bit ov,
                       input bit wz, input bit wn, input bit wv,
                       input bit bv, input bit [2:0] c);
    @(negedge clk);
    rst = r; stall = s; flush = f;
    alu_zr = zr; alu_neg = ng; alu_ov = ov;
    wr_z = wz; wr_n = wn; wr_v = wv;
    br_valid = bv; br_cond = c;
    #1;
    m_haz = model_hazard();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      n_tests++;
      if (hazard_stall !== 1'b0) begin
        n_fail++; $display("FAIL reset_hazard got=%b exp=0", hazard_stall);
      end
      tick();
      n_tests++;
      if ({flag_z, flag_n, flag_v, br_taken, br_resolved} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs got zn v t r=%b%b%b%b%b exp=00000",
                 flag_z, flag_n, flag_v, br_taken, br_resolved);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0, 3'($urandom));
      tick();
      n_tests++;
      if ({flag_z, flag_n, flag_v} !== 3'b000) begin
        n_fail++; $display("FAIL flags_hold_after_reset got=%b%b%b exp=000", flag_z, flag_n, flag_v);
      end
    end
  endtask

  task automatic test_flag_write();
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3'd0);
    tick();
    n_tests++;
    if ({flag_z, flag_n, flag_v} !== 3'b100) begin
      n_fail++; $display("FAIL single_write_z got=%b%b%b exp=100", flag_z, flag_n, flag_v);
    end
    // Stalled write of the opposite values must leave the flags alone.
    drive(0, 1, 0, 0, 1, 1, 1, 1, 1, 0, 3'd0);
    tick();
    n_tests++;
    if ({flag_z, flag_n, flag_v} !== 3'b100) begin
      n_fail++; $display("FAIL stalled_write got=%b%b%b exp=100", flag_z, flag_n, flag_v);
    end
    drive(0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 3'd0);
    tick();
    n_tests++;
    if ({flag_z, flag_n, flag_v} !== 3'b100) begin
      n_fail++; $display("FAIL flushed_write got=%b%b%b exp=100", flag_z, flag_n, flag_v);
    end
    drive(0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 3'd0);
    tick();
    n_tests++;
    if ({flag_z, flag_n, flag_v} !== 3'b101) begin
      n_fail++; $display("FAIL single_write_v got=%b%b%b exp=101", flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_cond_sweep();
    bit [7:0] exp_seq;
    exp_seq = 8'b1010_1001; // bit i = expected taken for cond i with Z=0,N=1,V=0
    drive(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 3'd0);
    tick();
    for (int unsigned c = 0; c < 8; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'(c));
      tick();
      n_tests++;
      if (br_resolved !== 1'b1 || br_taken !== exp_seq[c]) begin
        n_fail++;
        $display("FAIL cond_sweep_%0d got res=%b taken=%b exp res=1 taken=%b",
                 c, br_resolved, br_taken, exp_seq[c]);
      end
    end
  endtask

  task automatic test_hazard();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 3'd1);
    n_tests++;
    if (hazard_stall !== !BYPASS) begin
      n_fail++; $display("FAIL hazard_assert got=%b exp=%b", hazard_stall, !BYPASS);
    end
    tick();
    n_tests++;
    if (br_resolved !== BYPASS || br_taken !== BYPASS) begin
      n_fail++;
      $display("FAIL hazard_t1 got res=%b taken=%b exp res=%b taken=%b",
               br_resolved, br_taken, BYPASS, BYPASS);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1);
    n_tests++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_wait_clear got=%b exp=0", hazard_stall);
    end
    tick();
    n_tests++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL hazard_t2 got res=%b taken=%b exp res=1 taken=1", br_resolved, br_taken);
    end
  endtask

  task automatic test_wait_abort();
    // Flush while waiting
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 3'd1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3'd1);
    tick();
    n_tests++;
    if (br_resolved !== 1'b0 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL wait_flush got res=%b taken=%b exp 0 0", br_resolved, br_taken);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1);
    n_tests++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL after_flush_hazard got=%b exp=0", hazard_stall);
    end
    tick();
    n_tests++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL after_flush_branch got res=%b taken=%b exp 1 1", br_resolved, br_taken);
    end
    // Reset while waiting
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 3'd7);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7);
    tick();
    n_tests++;
    if ({br_resolved, br_taken, flag_z} !== 3'b000) begin
      n_fail++;
      $display("FAIL wait_reset got res=%b taken=%b z=%b exp 0 0 0", br_resolved, br_taken, flag_z);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0);
    tick();
    n_tests++;
    if (br_resolved !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_branch got res=%b taken=%b exp 1 1", br_resolved, br_taken);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(49) == 0), ($urandom_range(5) == 0), ($urandom_range(7) == 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom));
      n_tests++;
      if (hazard_stall !== m_haz) begin
        n_fail++; $display("FAIL rand_hazard cyc=%0d got=%b exp=%b", i, hazard_stall, m_haz);
      end
      tick();
      n_tests++;
      if ({flag_z, flag_n, flag_v, br_resolved, br_taken} !== {m_z, m_n, m_v, m_res, m_taken}) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got zn v r t=%b%b%b%b%b exp=%b%b%b%b%b", i,
                 flag_z, flag_n, flag_v, br_resolved, br_taken, m_z, m_n, m_v, m_res, m_taken);
      end
    end
  endtask

  initial begin
    {rst, stall, flush, alu_zr, alu_neg, alu_ov, wr_z, wr_n, wr_v, br_valid} = '0;
    br_cond = '0;
    test_reset();
    test_flag_write();
    test_cond_sweep();
    test_hazard();
    test_wait_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
